// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory-stage access unit:
// opcode/state encodings, request bundle and legality rule.
package mem_access_unit_pkg;

    localparam int cMemXlen     = 32;
    localparam int cMemRegAddrW = 5;
    localparam int cMemTimeout  = 255;

    typedef enum logic [2:0] {
        eMemB  = 3'b000,
        eMemH  = 3'b001,
        eMemW  = 3'b010,
        eMemBU = 3'b100,
        eMemHU = 3'b101
    } tMemOpType;

    typedef enum logic [1:0] {
        eIdle,
        eReq,
        eWait
    } tMemAccState;

    typedef struct packed {
        logic                    read;
        logic                    write;
        logic [cMemXlen-1:0]     addr;
        logic [cMemXlen-1:0]     data;
        tMemOpType               opType;
        logic [cMemRegAddrW-1:0] rdAddr;
    } tMemReq;

    function automatic logic memReqLegal(
        input logic       rd,
        input logic       wr,
        input logic [2:0] op,
        input logic [1:0] off
    );
        logic ok;
        ok = 1'b1;
        if (rd && wr) ok = 1'b0;
        if (rd && !(op inside {3'b000, 3'b001, 3'b010,
                               3'b100, 3'b101}))
            ok = 1'b0;
        if (wr && op > 3'b010) ok = 1'b0;
        // Halfword needs even, word needs 4-byte alignment.
        if ((rd || wr) && op[1:0] == 2'b01 && off[0])
            ok = 1'b0;
        if ((rd || wr) && op[1:0] == 2'b10 && off != 2'b00)
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request, data-bus and writeback signals of the memory access unit.
// slave = the unit itself, master = its environment.
interface mem_access_unit_if
    import mem_access_unit_pkg::*;
#(
    parameter int cXLEN     = cMemXlen,
    parameter int cRegAddrW = cMemRegAddrW
);
    logic                 iMemValid;
    logic                 oMemReady;
    logic                 iMemRead;
    logic                 iMemWrite;
    logic [cXLEN-1:0]     iMemAddr;
    logic [cXLEN-1:0]     iMemData;
    logic [2:0]           iMemOpType;
    logic [cRegAddrW-1:0] iMemRdAddr;
    logic                 oBusReq;
    logic                 oBusWe;
    logic [cXLEN-1:0]     oBusAddr;
    logic [cXLEN-1:0]     oBusWData;
    logic [3:0]           oBusBe;
    logic                 iBusGnt;
    logic                 iBusRValid;
    logic [cXLEN-1:0]     iBusRData;
    logic                 oRegDv;
    logic [cRegAddrW-1:0] oRegAddr;
    logic [cXLEN-1:0]     oRegData;
    logic                 oFault;
    logic                 oBusy;

    modport slave (
        input  iMemValid, iMemRead, iMemWrite,
        input  iMemAddr, iMemData, iMemOpType,
        input  iMemRdAddr,
        input  iBusGnt, iBusRValid, iBusRData,
        output oMemReady,
        output oBusReq, oBusWe, oBusAddr,
        output oBusWData, oBusBe,
        output oRegDv, oRegAddr, oRegData,
        output oFault, oBusy
    );

    modport master (
        output iMemValid, iMemRead, iMemWrite,
        output iMemAddr, iMemData, iMemOpType,
        output iMemRdAddr,
        output iBusGnt, iBusRValid, iBusRData,
        input  oMemReady,
        input  oBusReq, oBusWe, oBusAddr,
        input  oBusWData, oBusBe,
        input  oRegDv, oRegAddr, oRegData,
        input  oFault, oBusy
    );

endinterface

// File: rtl/mem_load_align.sv
// Load lane select and sign/zero extension of a bus read word.
module mem_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [cMemXlen-1:0] iRData,
    input  logic [1:0]          iByteOff,
    input  tMemOpType           iOpType,
    output logic [cMemXlen-1:0] oData
);

    logic [cMemXlen-1:0] lane;

    assign lane = iRData >> {iByteOff, 3'b000};

    always_comb begin
        oData = lane;
        unique case (iOpType)
            eMemB:   oData = {{24{lane[7]}}, lane[7:0]};
            eMemH:   oData = {{16{lane[15]}}, lane[15:0]};
            eMemBU:  oData = {24'b0, lane[7:0]};
            eMemHU:  oData = {16'b0, lane[15:0]};
            default: oData = lane;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store responder: one request at a time on a
// req/gnt + rvalid word bus, load results returned as a writeback.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int cXLEN     = cMemXlen,
    parameter int cRegAddrW = cMemRegAddrW,
    parameter int cTimeout  = cMemTimeout
) (
    input logic              iClk,
    input logic              iRst,
    mem_access_unit_if.slave mau
);

    localparam int cCntW = $clog2(cTimeout + 1);

    tMemAccState          state;
    tMemReq               req;
    logic [cCntW-1:0]     toCnt;
    logic                 busReq;
    logic                 regDv;
    logic                 fault;
    logic [cRegAddrW-1:0] regAddr;
    logic [cXLEN-1:0]     regData;
    logic [cXLEN-1:0]     ldData;
    logic [cXLEN-1:0]     stData;
    logic [3:0]           stBe;
    logic                 accept;
    logic                 legal;
    logic                 timedOut;

    assign accept   = mau.iMemValid && (state == eIdle);
    assign legal    = memReqLegal(mau.iMemRead, mau.iMemWrite,
                                  mau.iMemOpType,
                                  mau.iMemAddr[1:0]);
    assign timedOut = (toCnt >= cCntW'(cTimeout - 1));

    // Lanes come from the captured request, so they hold
    // steady for the whole REQ phase.
    always_comb begin
        stBe   = 4'b1111;
        stData = req.data;
        unique case (1'b1)
            (req.opType[1:0] == 2'b00): begin
                stBe   = 4'b0001 << req.addr[1:0];
                stData = {4{req.data[7:0]}};
            end
            (req.opType[1:0] == 2'b01): begin
                stBe   = 4'b0011 << req.addr[1:0];
                stData = {2{req.data[15:0]}};
            end
            default: ;
        endcase
    end

    mem_load_align uAlign (
        .iRData  (mau.iBusRData),
        .iByteOff(req.addr[1:0]),
        .iOpType (req.opType),
        .oData   (ldData)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state   <= eIdle;
            req     <= '0;
            toCnt   <= '0;
            busReq  <= 1'b0;
            regDv   <= 1'b0;
            regAddr <= '0;
            regData <= '0;
            fault   <= 1'b0;
        end else begin
            regDv <= 1'b0;
            fault <= 1'b0;
            unique case (state)
                eIdle: begin
                    toCnt <= '0;
                    if (accept) begin
                        req <= '{
                            read:   mau.iMemRead,
                            write:  mau.iMemWrite,
                            addr:   mau.iMemAddr,
                            data:   mau.iMemData,
                            opType: tMemOpType'(mau.iMemOpType),
                            rdAddr: mau.iMemRdAddr
                        };
                        if (!legal) begin
                            fault <= 1'b1;
                        end else if (mau.iMemRead ||
                                     mau.iMemWrite) begin
                            state  <= eReq;
                            busReq <= 1'b1;
                        end
                    end
                end
                eReq: begin
                    if (mau.iBusGnt) begin
                        busReq <= 1'b0;
                        if (req.read) begin
                            state <= eWait;
                            toCnt <= toCnt + 1'b1;
                        end else begin
                            state <= eIdle;
                            toCnt <= '0;
                        end
                    end else if (timedOut) begin
                        busReq <= 1'b0;
                        fault  <= 1'b1;
                        state  <= eIdle;
                        toCnt  <= '0;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                eWait: begin
                    if (mau.iBusRValid) begin
                        regDv   <= (req.rdAddr != '0);
                        regAddr <= req.rdAddr;
                        regData <= ldData;
                        state   <= eIdle;
                        toCnt   <= '0;
                    end else if (timedOut) begin
                        fault <= 1'b1;
                        state <= eIdle;
                        toCnt <= '0;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                default: state <= eIdle;
            endcase
        end
    end

    assign mau.oMemReady = (state == eIdle);
    assign mau.oBusy     = (state != eIdle);
    assign mau.oBusReq   = busReq;
    assign mau.oBusWe    = req.write;
    assign mau.oBusAddr  = {req.addr[cXLEN-1:2], 2'b00};
    assign mau.oBusWData = stData;
    assign mau.oBusBe    = busReq ? stBe : 4'b0000;
    assign mau.oRegDv    = regDv;
    assign mau.oRegAddr  = regAddr;
    assign mau.oRegData  = regData;
    assign mau.oFault    = fault;

endmodule
